// File: rtl/spi_master_driver_if.sv
// Host-side and SPI-side signals of spi_master_driver.
// Modport master is the driver's own view; slave is the host/bench view. SPI_MASTER_IRQ_EN adds irq_o/irq_clr_i.
interface spi_master_driver_if;
    logic       start_i;
    logic [7:0] data_in_bi;
    logic       busy_o;
    logic       done_o;
    logic [7:0] data_out_bo;
    logic       spi_sclk_o;
    logic       spi_mosi_o;
    logic       spi_miso_i;
    logic       spi_cs_o;
`ifdef SPI_MASTER_IRQ_EN
    logic       irq_o;
    logic       irq_clr_i;
`endif

    modport master (
        input  start_i, data_in_bi, spi_miso_i,
        output busy_o, done_o, data_out_bo, spi_sclk_o, spi_mosi_o, spi_cs_o
`ifdef SPI_MASTER_IRQ_EN
        , input irq_clr_i, output irq_o
`endif
    );

    modport slave (
        output start_i, data_in_bi, spi_miso_i,
        input  busy_o, done_o, data_out_bo, spi_sclk_o, spi_mosi_o, spi_cs_o
`ifdef SPI_MASTER_IRQ_EN
        , output irq_clr_i, input irq_o
`endif
    );
endinterface

// File: rtl/spi_master_driver.sv
// Single-byte SPI master, CPOL=0 CPHA=0, LSB first, full duplex, all outputs registered.
// Optional sticky completion flag irq_o enabled by defining SPI_MASTER_IRQ_EN.
module spi_master_driver #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_IDLE  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    spi_master_driver_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCLK_HIGH,
        SCLK_LOW,
        HOLD,
        GAP
    } state_t;

    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
    localparam logic [15:0] IDLE_LAST  = 16'(CS_IDLE - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  dout_q, dout_d;
    logic        sclk_q, sclk_d;
    logic        cs_q, cs_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // cnt counts cycles spent in the current state; each state acts on its last cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.start_i) begin
                    tx_d    = bus.data_in_bi;
                    cs_d    = 1'b0;
                    bit_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    rx_d    = {bus.spi_miso_i, rx_q[7:1]};
                    state_d = SCLK_HIGH;
                end
            end
            SCLK_HIGH: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d  = '0;
                    sclk_d = 1'b0;
                    tx_d   = {1'b0, tx_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = HOLD;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        state_d = SCLK_LOW;
                    end
                end
            end
            SCLK_LOW: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    rx_d    = {bus.spi_miso_i, rx_q[7:1]};
                    state_d = SCLK_HIGH;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    dout_d  = rx_q;
                    done_d  = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q == IDLE_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Registered copies track the next state so busy/MOSI line up with the state register.
        busy_d = (state_d != IDLE);
        mosi_d = cs_d ? 1'b0 : tx_d[0];
    end

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.data_out_bo = dout_q;
    assign bus.spi_sclk_o  = sclk_q;
    assign bus.spi_mosi_o  = mosi_q;
    assign bus.spi_cs_o    = cs_q;

`ifdef SPI_MASTER_IRQ_EN
    logic irq_q;

    // Setting on both the rising done edge and the visible done cycle keeps a clear
    // that coincides with the done_o pulse from dropping the event.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_q <= 1'b0;
        end else if (done_d || done_q) begin
            irq_q <= 1'b1;
        end else if (bus.irq_clr_i) begin
            irq_q <= 1'b0;
        end
    end

    assign bus.irq_o = irq_q;
`endif

endmodule

// File: tb/tb_spi_master_driver.sv
// Bench for spi_master_driver: behavioural SPI slave model plus timing expectations derived from the parameters.
module tb_spi_master_driver;

    localparam int DIV   = 4;
    localparam int SETUP = 2;
    localparam int HOLDC = 2;
    localparam int IDLEC = 2;

    localparam int E_RISE  = SETUP;
    localparam int E_LFALL = SETUP + 15 * DIV;
    localparam int E_DONE  = E_LFALL + HOLDC;
    localparam int E_BUSYL = E_DONE + IDLEC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic       start = 1'b0;
    logic       start1 = 1'b0;
    logic [7:0] din = '0;
    logic       miso0 = 1'b0;
    logic [7:0] stx = '0;
    logic [7:0] srx = '0;
    int         sidx = 0;
`ifdef SPI_MASTER_IRQ_EN
    logic       irq_clr = 1'b0;
`endif

    spi_master_driver_if if0 ();
    spi_master_driver_if if1 ();

    assign if0.start_i    = start;
    assign if0.data_in_bi = din;
    assign if0.spi_miso_i = miso0;
    assign if1.start_i    = start1;
    assign if1.data_in_bi = 8'h00;
    assign if1.spi_miso_i = 1'b1;
`ifdef SPI_MASTER_IRQ_EN
    assign if0.irq_clr_i  = irq_clr;
    assign if1.irq_clr_i  = 1'b0;
`endif

    spi_master_driver #(.CLK_DIV(DIV), .CS_SETUP(SETUP), .CS_HOLD(HOLDC), .CS_IDLE(IDLEC))
        dut (.clk_i(clk), .rst_i(rst), .bus(if0));

    spi_master_driver #(.CLK_DIV(1), .CS_SETUP(SETUP), .CS_HOLD(HOLDC), .CS_IDLE(IDLEC))
        dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));

    // Slave model: presents bit 0 on CS fall, next bit after each SCLK fall, captures MOSI on SCLK rise.
    always @(negedge if0.spi_cs_o) begin
        sidx  = 0;
        srx   = '0;
        miso0 = stx[0];
    end

    always @(negedge if0.spi_sclk_o) begin
        if (!if0.spi_cs_o) begin
            sidx  = sidx + 1;
            miso0 = (sidx < 8) ? stx[sidx] : 1'b0;
        end
    end

    always @(posedge if0.spi_sclk_o) begin
        if (!if0.spi_cs_o) srx = {if0.spi_mosi_o, srx[7:1]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the following posedge is t0. Offsets k are sampled at the negedge after edge t0+k.
    task automatic xfer(input logic [7:0] mtx, input logic [7:0] sbyte, input bit hold, input bit poke);
        int rise_k = -1, lfall_k = -1, csh_k = -1, done_k = -1, busyl_k = -1;
        int rises = 0, falls = 0, dones = 0;
        logic ps = 1'b0, pc = 1'b0;
        stx   = sbyte;
        din   = mtx;
        start = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = hold;
                check("cs_low_t0", {31'd0, if0.spi_cs_o}, 32'd0);
                check("busy_t0", {31'd0, if0.busy_o}, 32'd1);
            end
            if (poke && k == 9) begin
                start = 1'b1;
                din   = 8'hFF;
            end
            if (poke && k == 10) start = 1'b0;
            if (if0.spi_sclk_o && !ps) begin
                rises++;
                if (rise_k < 0) rise_k = k;
            end
            if (!if0.spi_sclk_o && ps) begin
                falls++;
                lfall_k = k;
            end
            if (if0.spi_cs_o && !pc) csh_k = k;
            if (if0.done_o) begin
                dones++;
                done_k = k;
            end
            ps = if0.spi_sclk_o;
            pc = if0.spi_cs_o;
            if (!if0.busy_o) begin
                busyl_k = k;
                break;
            end
        end
        check("timeout", {31'd0, busyl_k >= 0}, 32'd1);
        check("first_rise", rise_k, E_RISE);
        check("rises", rises, 8);
        check("falls", falls, 8);
        check("last_fall", lfall_k, E_LFALL);
        check("cs_high", csh_k, E_DONE);
        check("done_at", done_k, E_DONE);
        check("done_count", dones, 1);
        check("busy_low", busyl_k, E_BUSYL);
        check("rx_data", {24'd0, if0.data_out_bo}, {24'd0, sbyte});
        check("slave_rx", {24'd0, srx}, {24'd0, mtx});
        check("mosi_idle", {31'd0, if0.spi_mosi_o}, 32'd0);
    endtask

    initial begin
        logic [7:0] a, b;
        int lf, dk, rs;
        logic ps1;

        repeat (3) @(negedge clk);
        check("rst_cs", {31'd0, if0.spi_cs_o}, 32'd1);
        check("rst_sclk", {31'd0, if0.spi_sclk_o}, 32'd0);
        check("rst_busy", {31'd0, if0.busy_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_done", {31'd0, if0.done_o}, 32'd0);
        check("idle_dout", {24'd0, if0.data_out_bo}, 32'd0);
        check("idle_mosi", {31'd0, if0.spi_mosi_o}, 32'd0);

        // Abort by reset around t0+30.
        stx   = 8'h99;
        din   = 8'hC3;
        start = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
        end
        check("pre_rst_cs", {31'd0, if0.spi_cs_o}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("abort_cs", {31'd0, if0.spi_cs_o}, 32'd1);
        check("abort_sclk", {31'd0, if0.spi_sclk_o}, 32'd0);
        check("abort_busy", {31'd0, if0.busy_o}, 32'd0);
        check("abort_done", {31'd0, if0.done_o}, 32'd0);
        check("abort_dout", {24'd0, if0.data_out_bo}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_done", {31'd0, if0.done_o}, 32'd0);
        check("post_rst_dout", {24'd0, if0.data_out_bo}, 32'd0);

        xfer(8'h5A, 8'h6E, 1'b0, 1'b0);
        xfer(8'hA5, 8'h3C, 1'b0, 1'b0);
        xfer(8'h01, 8'h80, 1'b0, 1'b0);

        a = 8'($urandom);
        b = 8'($urandom);
        xfer(a, b, 1'b0, 1'b1);

        // Start held high: the second call's t0 checks show busy dropped for one cycle only.
        a = 8'($urandom);
        b = 8'($urandom);
        xfer(a, b, 1'b1, 1'b0);
        a = 8'($urandom);
        b = 8'($urandom);
        xfer(a, b, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        for (int n = 0; n < 4; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            xfer(a, b, 1'b0, 1'b0);
        end

        // CLK_DIV=1 instance with MISO tied high.
        lf = -1; dk = -1; rs = 0; ps1 = 1'b0;
        start1 = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 0) start1 = 1'b0;
            if (if1.spi_sclk_o && !ps1) rs++;
            if (!if1.spi_sclk_o && ps1) lf = k;
            if (if1.done_o) dk = k;
            ps1 = if1.spi_sclk_o;
            if (!if1.busy_o) break;
        end
        check("div1_last_fall", lf, SETUP + 15);
        check("div1_done", dk, SETUP + 15 + HOLDC);
        check("div1_rises", rs, 8);
        check("div1_dout", {24'd0, if1.data_out_bo}, 32'hFF);

`ifdef SPI_MASTER_IRQ_EN
        check("irq_set", {31'd0, if0.irq_o}, 32'd1);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check("irq_cleared", {31'd0, if0.irq_o}, 32'd0);
        stx   = 8'h12;
        din   = 8'h34;
        start = 1'b1;
        dk    = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (dk < 0 && k < E_DONE) check("irq_quiet", {31'd0, if0.irq_o}, 32'd0);
            if (dk >= 0 && k == dk + 1) begin
                check("irq_set_wins", {31'd0, if0.irq_o}, 32'd1);
                irq_clr = 1'b0;
            end
            if (if0.done_o) begin
                dk = k;
                check("irq_with_done", {31'd0, if0.irq_o}, 32'd1);
                irq_clr = 1'b1;
            end
            if (!if0.busy_o) break;
        end
        check("irq_done_seen", dk, E_DONE);
        check("irq_sticky", {31'd0, if0.irq_o}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
